mdu_sched: RTL
==============

# mdu_sched

Multi-cycle scheduler for the multiply/divide unit in the pipelined MIPS core. It sits beside the E stage and owns the HI/LO registers. It launches mult/div/maddu operations, counts their latency, and commits results to HI/LO on completion. While a long operation is in flight it holds back any further MDU instruction by raising `stall` to the hazard logic.

## Interface
Parameters:
- `MULT_LAT`, 5: busy cycles for MULT/MULTU/MADDU (must be ≥1).
- `DIV_LAT`, 10: busy cycles for DIV/DIVU (must be ≥1).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `op_valid` in 1: E-stage instruction is a live MDU instruction.
- `op` in 4: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADDU; 10–15 treated as NONE.
- `d1` in 32: rs operand.
- `d2` in 32: rt operand.
- `stall` out 1: freeze F/D/E and insert a bubble into M.
- `busy` out 1: long operation in flight.
- `rdata` out 32: HI for MFHI, LO for MFLO, else 0. Combinational from the current HI/LO.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.

## Operation
- FSM states are IDLE and RUN. The block also holds a counter `cnt` (4 bits minimum) and pending registers `phi`/`plo` plus a pending op code.
- An instruction is accepted when `op_valid && op!=NONE && !stall`.
- `stall = op_valid && op!=NONE && busy`. Every MDU op, including MFHI/MFLO/MTHI/MTLO, stalls while busy.
- Accepted MULT/MULTU/DIV/DIVU/MADDU in IDLE:
  - Compute the result from `d1`/`d2` and latch it into `phi`/`plo`.
  - Load `cnt` = latency−1 and go to RUN.
  - MADDU latches the unsigned product only. The accumulate is applied at commit.
- RUN:
  - `cnt` decrements each cycle.
  - On the edge where `cnt==0`, commit and return to IDLE:
    - MULT/MULTU/DIV/DIVU: `{hi,lo}` ← `{phi,plo}`.
    - MADDU: `{hi,lo}` ← `{hi,lo}` + `{phi,plo}`, 64-bit, carry out discarded.
- MTHI/MTLO accepted: `hi` or `lo` ← `d1` at that edge. No state change.
- MFHI/MFLO do not change state.
- Arithmetic rules:
  - MULT is a signed 32×32→64 multiply; MULTU is unsigned.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - Divisor 0: HI/LO unchanged after commit, and the full DIV_LAT still elapses.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Ops cannot be cancelled. A flush of the E stage after acceptance does not abort the operation.
- `rst` at any cycle, including mid-RUN: IDLE, `cnt`=0, `hi`=`lo`=`phi`=`plo`=0. The pending op is discarded.

## Timing
- Reset values: `busy`=0, `stall`=0, `hi`=0, `lo`=0, `rdata`=0.
- `busy` is 1 exactly when the FSM is in RUN.
- Accept at edge E0: `busy` is high for exactly LAT cycles after E0, i.e. from E0 until edge E0+LAT.
- HI/LO show the new value from edge E0+LAT onward, and `busy` falls at that same edge.
- The accepting cycle itself has `busy`=0, so it is not stalled.
- Back-to-back ops:
  - A second long op presented right after the first stalls for LAT cycles and is accepted at edge E0+LAT.
  - Its result is therefore visible at E0+2·LAT.
- MFHI presented during RUN stalls. It is accepted in the first IDLE cycle, and `rdata` then returns the committed value.
- MTHI/MTLO write at their accept edge, and MFHI in the following cycle sees the value.
- `stall` and `rdata` are combinational from registered state and the inputs in the same cycle.

## Test plan
- MULT `d1`=0xFFFFFFFE (−2), `d2`=3, then MFLO held valid:
  - `busy` high for 5 cycles and `stall` high for 5 cycles.
  - Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA, and `rdata`=0xFFFFFFFA.
- DIV −7/2:
  - 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2 gives lo=3, hi=1.
- DIV by 0 after MTHI 0x11, MTLO 0x22:
  - Still 10 busy cycles.
  - hi=0x11 and lo=0x22 are unchanged.
- MTHI 0xFFFFFFFF, MTLO 0xFFFFFFFF, then MADDU 1×1:
  - After 5 cycles hi=0, lo=0 (64-bit wrap).
  - MULTU 0xFFFFFFFF×0xFFFFFFFF gives hi=0xFFFFFFFE, lo=1.
- MULT issued, then DIV held valid:
  - DIV stalls 5 cycles and is accepted at edge 5.
  - Final result appears at edge 15.
  - No op is lost or duplicated.
- `rst` asserted at busy cycle 3 of a DIV:
  - Next cycle `busy`=0 and hi=lo=0.
  - No late commit appears over the following 10 cycles.

Source files
------------

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler beside the E stage: launches MDU ops, times their
// latency, owns HI/LO and stalls further MDU instructions while one is in flight.
module mdu_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 16) ? $clog2(MAX_LAT) : 4;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_load;
  logic [31:0]        phi, plo;
  logic [3:0]         pop;
  logic               pskip;
  logic               is_op, is_long, is_div, accept, launch;
  logic [63:0]        res;

  function automatic logic signed [63:0] smul(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] ea, eb;
    ea = $signed({{32{a[31]}}, a});
    eb = $signed({{32{b[31]}}, b});
    return ea * eb;
  endfunction

  // Divide on magnitudes so the 0x80000000 / -1 case never overflows.
  function automatic logic [63:0] sdiv(input logic signed [31:0] a,
                                       input logic signed [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q  = (mb == 32'd0) ? 32'd0 : ma / mb;
    r  = (mb == 32'd0) ? 32'd0 : ma % mb;
    if (a[31] ^ b[31]) q = -q;
    if (a[31])         r = -r;
    return {r, q};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  assign is_op   = (op >= OP_MULT) && (op <= OP_MADDU);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign is_long = (op <= OP_DIVU && op != 4'd0) || (op == OP_MADDU);
  assign busy    = (state == RUN);
  assign stall   = op_valid && is_op && busy;
  assign accept  = op_valid && is_op && !stall;
  assign launch  = accept && is_long;

  always_comb begin
    rdata = 32'd0;
    if (op_valid && op == OP_MFHI) rdata = hi;
    if (op_valid && op == OP_MFLO) rdata = lo;
  end

  always_comb begin
    res      = 64'd0;
    cnt_load = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
    case (op)
      OP_MULT:           res = smul(d1, d2);
      OP_MULTU, OP_MADDU: res = {32'd0, d1} * {32'd0, d2};
      OP_DIV:            res = sdiv(d1, d2);
      OP_DIVU:           res = udiv(d1, d2);
      default:           res = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Launch latches the result; commit fires on the cnt==0 edge of RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      pop   <= 4'd0;
      pskip <= 1'b0;
    end else if (launch) begin
      {phi, plo} <= res;
      pop        <= op;
      pskip      <= is_div && (d2 == 32'd0);
      cnt        <= cnt_load;
    end else if (busy) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (!pskip) begin
        if (pop == OP_MADDU) {hi, lo} <= {hi, lo} + {phi, plo};
        else                 {hi, lo} <= {phi, plo};
      end
    end else if (accept && op == OP_MTHI) begin
      hi <= d1;
    end else if (accept && op == OP_MTLO) begin
      lo <= d1;
    end
  end

endmodule
